// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, real-time passthrough filtering,
// channel filter, partial-message timeout and single-note tracking.
module midi_msg_parser #(
    parameter bit          OMNI           = 1'b1,
    parameter logic [3:0]  CHANNEL        = 4'd0,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [23:0] out_bytes,
    output logic        out_valid,
    output logic        note_active,
    output logic [6:0]  note_num,
    output logic [6:0]  note_vel,
    output logic        err
);

    localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2, SKIP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    run_status;
    logic [7:0]    data1;
    logic [CW-1:0] cnt;

    logic          is_rt, is_sys, is_chan, is_data;
    logic          one_byte, accepted, tmo_hit;
    logic          emit, take_d1, err_set;
    logic [23:0]   msg;

    assign is_rt    = in_valid && (in_byte[7:3] == 5'b11111);
    assign is_sys   = in_valid && (in_byte[7:3] == 5'b11110);
    assign is_chan  = in_valid && in_byte[7] && (in_byte[7:4] != 4'hF);
    assign is_data  = in_valid && !in_byte[7];
    assign one_byte = (run_status[7:5] == 3'b110);
    assign accepted = OMNI || (run_status[3:0] == CHANNEL);
    // Only a held data1 can time out; any arriving byte (even a status) pre-empts it.
    assign tmo_hit  = !in_valid && (state == WAIT_D2) && (cnt == TMO_M1);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        take_d1   = 1'b0;
        err_set   = 1'b0;
        msg       = {run_status, data1, in_byte};
        if (is_chan) begin
            state_nxt = WAIT_D1;
        end else if (is_sys) begin
            state_nxt = SKIP;
        end else if (is_data) begin
            case (state)
                NO_STATUS: err_set = 1'b1;
                WAIT_D1: begin
                    if (one_byte) begin
                        emit = 1'b1;
                        msg  = {run_status, in_byte, 8'h00};
                    end else begin
                        take_d1   = 1'b1;
                        state_nxt = WAIT_D2;
                    end
                end
                WAIT_D2: begin
                    emit      = 1'b1;
                    state_nxt = WAIT_D1;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            err_set   = 1'b1;
            state_nxt = WAIT_D1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NO_STATUS;
            run_status  <= 8'h00;
            data1       <= 8'h00;
            cnt         <= '0;
            out_bytes   <= 24'h0;
            out_valid   <= 1'b0;
            note_active <= 1'b0;
            note_num    <= 7'h0;
            note_vel    <= 7'h0;
            err         <= 1'b0;
        end else begin
            state     <= state_nxt;
            err       <= err_set;
            out_valid <= emit && accepted;
            if (is_chan)
                run_status <= in_byte;
            else if (is_sys)
                run_status <= 8'h00;
            if (take_d1)
                data1 <= in_byte;
            // Real-time bytes are invisible to the idle timer.
            if (in_valid && !is_rt)
                cnt <= '0;
            else if (!in_valid && cnt != TMO)
                cnt <= cnt + CW'(1);
            if (emit && accepted) begin
                out_bytes <= msg;
                case (msg[23:20])
                    4'h8: if (msg[14:8] == note_num) note_active <= 1'b0;
                    4'h9: begin
                        if (msg[6:0] != 7'h0) begin
                            note_active <= 1'b1;
                            note_num    <= msg[14:8];
                            note_vel    <= msg[6:0];
                        end else if (msg[14:8] == note_num) begin
                            note_active <= 1'b0;
                        end
                    end
                    4'hB: if (msg[15:8] == 8'h7B) note_active <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Drives one byte stream into an omni parser and a channel-0-only parser and
// compares both against a message-level reference model every cycle.
module tb_midi_msg_parser;

    localparam int T = 20;

    logic        clk, rst, in_valid;
    logic [7:0]  in_byte;
    logic [23:0] ob   [2];
    logic        ov   [2];
    logic        na   [2];
    logic [6:0]  nn   [2];
    logic [6:0]  nv   [2];
    logic        er   [2];

    midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0), .TIMEOUT_CYCLES(T)) u_omni (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .out_bytes(ob[0]), .out_valid(ov[0]), .note_active(na[0]),
        .note_num(nn[0]), .note_vel(nv[0]), .err(er[0]));

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd0), .TIMEOUT_CYCLES(T)) u_ch0 (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .out_bytes(ob[1]), .out_valid(ov[1]), .note_active(na[1]),
        .note_num(nn[1]), .note_vel(nv[1]), .err(er[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: running status plus a queue of collected data bytes.
    logic [7:0]  m_rs;
    bit          m_have, m_skip;
    int          m_idle;
    logic [7:0]  m_q[$];
    logic [23:0] e_out [2];
    bit          e_val [2];
    bit          e_na  [2];
    logic [6:0]  e_nn  [2];
    logic [6:0]  e_nv  [2];
    bit          e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_rs = 8'h00; m_have = 0; m_skip = 0; m_idle = 0; m_q.delete(); e_err = 0;
        for (int i = 0; i < 2; i++) begin
            e_out[i] = 24'h0; e_val[i] = 0; e_na[i] = 0; e_nn[i] = 7'h0; e_nv[i] = 7'h0;
        end
    endtask

    task automatic model_complete();
        logic [7:0] d1, d2;
        d1 = m_q[0];
        d2 = (m_q.size() > 1) ? m_q[1] : 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (i == 0 || m_rs[3:0] == 4'd0) begin
                e_out[i] = {m_rs, d1, d2};
                e_val[i] = 1;
                if (m_rs[7:4] == 4'h9 && d2 != 0) begin
                    e_na[i] = 1; e_nn[i] = d1[6:0]; e_nv[i] = d2[6:0];
                end else if ((m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9) && d1[6:0] == e_nn[i]) begin
                    e_na[i] = 0;
                end else if (m_rs[7:4] == 4'hB && d1 == 8'h7B) begin
                    e_na[i] = 0;
                end
            end
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        int need;
        e_err = 0;
        for (int i = 0; i < 2; i++) e_val[i] = 0;
        if (v) begin
            if (b >= 8'hF8) begin
            end else begin
                m_idle = 0;
                if (b >= 8'hF0) begin
                    m_rs = 8'h00; m_have = 0; m_skip = 1; m_q.delete();
                end else if (b >= 8'h80) begin
                    m_rs = b; m_have = 1; m_skip = 0; m_q.delete();
                end else if (!m_have) begin
                    if (!m_skip) e_err = 1;
                end else begin
                    m_q.push_back(b);
                    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
                    if (m_q.size() == need) begin
                        model_complete();
                        m_q.delete();
                    end
                end
            end
        end else if (m_idle < T) begin
            m_idle++;
            if (m_idle == T && m_q.size() == 1) begin
                e_err = 1; m_q.delete();
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(e_val[i]));
            chk($sformatf("u%0d.out_bytes", i), 32'(ob[i]), 32'(e_out[i]));
            chk($sformatf("u%0d.err", i), 32'(er[i]), 32'(e_err));
            chk($sformatf("u%0d.note_active", i), 32'(na[i]), 32'(e_na[i]));
            chk($sformatf("u%0d.note_num", i), 32'(nn[i]), 32'(e_nn[i]));
            chk($sformatf("u%0d.note_vel", i), 32'(nv[i]), 32'(e_nv[i]));
        end
    endtask

    // One clock: apply input at negedge, sample results at the next negedge.
    task automatic cyc(input bit v, input logic [7:0] b);
        in_valid = v; in_byte = b;
        model_step(v, b);
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_byte = 8'h00;
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 0;
        check_all();
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] pick [4];
        pick[0] = 8'h3C; pick[1] = 8'h40; pick[2] = 8'h7B; pick[3] = 8'h00;
        if ($urandom_range(0, 1) == 0) return pick[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 127));
    endfunction

    initial begin
        rst = 1; in_valid = 0; in_byte = 8'h00;
        @(negedge clk);
        do_reset();
        chk("reset.out_bytes", 32'(ob[0]), 32'h0);
        chk("reset.note_active", 32'(na[0]), 32'h0);

        // Basic note-on and its one-cycle latency
        send(8'h90); send(8'h3C); send(8'h64);
        chk("noteon.out_bytes", 32'(ob[0]), 32'h903C64);
        chk("noteon.out_valid", 32'(ov[0]), 32'h1);
        chk("noteon.note_num", 32'(nn[0]), 32'h3C);
        chk("noteon.note_vel", 32'(nv[0]), 32'h64);
        cyc(0, 8'h00);
        chk("noteon.pulse_end", 32'(ov[0]), 32'h0);

        // Running status, then velocity-0 note-off of the held note
        send(8'h40); send(8'h50);
        chk("running.out_bytes", 32'(ob[0]), 32'h904050);
        chk("running.note_num", 32'(nn[0]), 32'h40);
        send(8'h40); send(8'h00);
        chk("vel0.out_bytes", 32'(ob[0]), 32'h904000);
        chk("vel0.note_active", 32'(na[0]), 32'h0);
        chk("vel0.note_num_kept", 32'(nn[0]), 32'h40);

        // Real-time bytes interleaved
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        chk("rt.out_bytes", 32'(ob[0]), 32'h903C64);

        // Program change: omni emits, channel-0 filter drops channel 5
        send(8'hC5); send(8'h07);
        chk("pc.omni", 32'(ob[0]), 32'hC50700);
        chk("pc.ch0_valid", 32'(ov[1]), 32'h0);

        // Timeout after data1, running status survives
        send(8'h90); send(8'h3C);
        for (int k = 0; k < T - 1; k++) cyc(0, 8'h00);
        cyc(0, 8'h00);
        chk("tmo.err", 32'(er[0]), 32'h1);
        send(8'h3E); send(8'h7F);
        chk("tmo.resume", 32'(ob[0]), 32'h903E7F);

        // Status byte on the would-be timeout cycle
        send(8'h90); send(8'h3C);
        for (int k = 0; k < T - 1; k++) cyc(0, 8'h00);
        send(8'h91);
        chk("tmo.status_wins", 32'(er[0]), 32'h0);

        // Data with no status, and reset mid-message
        do_reset();
        send(8'h3C);
        chk("nostatus.err", 32'(er[0]), 32'h1);
        send(8'h90); send(8'h3C);
        do_reset();
        chk("midrst.out_bytes", 32'(ob[0]), 32'h0);
        send(8'h64);
        chk("midrst.err", 32'(er[0]), 32'h1);
        chk("midrst.valid", 32'(ov[0]), 32'h0);

        // CC 123 all-notes-off
        send(8'h90); send(8'h30); send(8'h10);
        send(8'hB0); send(8'h7B); send(8'h00);
        chk("cc123.note_active", 32'(na[0]), 32'h0);

        // Randomized traffic
        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)       send(rand_data());
            else if (r < 68)  send({1'b1, 3'($urandom_range(0, 6)),
                                    ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15))});
            else if (r < 72)  send(8'hF0 | 8'($urandom_range(0, 7)));
            else if (r < 82)  send(8'hF8 | 8'($urandom_range(0, 7)));
            else if (r < 99)  begin
                int n;
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(1, 4);
                for (int k = 0; k < n; k++) cyc(0, 8'h00);
            end
            else              do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
